// File: rtl/axi_cdc_iso_pkg.sv
// Shared types and default limits for the AXI CDC isolation controller.
package axi_cdc_iso_pkg;

  typedef enum logic [1:0] {
    ISO_RUN,
    ISO_DRAIN,
    ISO_ISOLATED
  } iso_state_e;

  localparam int unsigned DefaultMaxWrOutstanding = 16;
  localparam int unsigned DefaultMaxRdOutstanding = 16;
  localparam int unsigned DefaultTimeoutCycles    = 1024;

endpackage

// File: rtl/axi_cdc_iso_cnt.sv
// Saturating up/down transaction counter; simultaneous inc and dec cancel out.
module axi_cdc_iso_cnt #(
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic [Width-1:0] max_i,
  output logic [Width-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] count_q;

  assign full_o  = (count_q >= max_i);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Increments stall at max and decrements stall at zero so the count never wraps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (inc_i && !dec_i && !full_o) begin
      count_q <= count_q + Width'(1);
    end else if (dec_i && !inc_i && !empty_o) begin
      count_q <= count_q - Width'(1);
    end
  end

endmodule

// File: rtl/axi_cdc_isolate_ctrl.sv
// Source-side quiesce/isolation controller for an AXI clock-domain crossing.
// Optional drain timeout enabled by defining AXI_CDC_ISO_TIMEOUT_EN.
module axi_cdc_isolate_ctrl
  import axi_cdc_iso_pkg::*;
#(
  parameter int unsigned MaxWrOutstanding = DefaultMaxWrOutstanding,
  parameter int unsigned MaxRdOutstanding = DefaultMaxRdOutstanding,
  parameter int unsigned TimeoutCycles    = DefaultTimeoutCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic isolate_req_i,
  output logic isolated_o,
  input  logic slv_aw_valid_i,
  output logic slv_aw_ready_o,
  output logic mst_aw_valid_o,
  input  logic mst_aw_ready_i,
  input  logic slv_ar_valid_i,
  output logic slv_ar_ready_o,
  output logic mst_ar_valid_o,
  input  logic mst_ar_ready_i,
  input  logic slv_w_valid_i,
  input  logic slv_w_last_i,
  output logic slv_w_ready_o,
  output logic mst_w_valid_o,
  input  logic mst_w_ready_i,
  input  logic mst_b_valid_i,
  output logic mst_b_ready_o,
  output logic slv_b_valid_o,
  input  logic slv_b_ready_i,
  input  logic mst_r_valid_i,
  input  logic mst_r_last_i,
  output logic mst_r_ready_o,
  output logic slv_r_valid_o,
  input  logic slv_r_ready_i,
  output logic [$clog2(MaxWrOutstanding+1)-1:0] wr_outstanding_o,
  output logic [$clog2(MaxRdOutstanding+1)-1:0] rd_outstanding_o,
  output logic timeout_o
);

  localparam int unsigned WrW = $clog2(MaxWrOutstanding + 1);
  localparam int unsigned RdW = $clog2(MaxRdOutstanding + 1);
  localparam logic [WrW-1:0] WrMax = WrW'(MaxWrOutstanding);
  localparam logic [RdW-1:0] RdMax = RdW'(MaxRdOutstanding);

  iso_state_e state_q;
  logic isolated_q, aw_lock_q, ar_lock_q;
  logic allow_aw, allow_ar, allow_w;
  logic aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;
  logic wr_full, wr_empty, rd_full, rd_empty, wp_full, wp_empty;
  logic [WrW-1:0] wp_count;
  logic unused_wp;

  assign unused_wp = ^{wp_count, wp_full};

  // A set lock keeps its channel open in every state so a presented valid never drops.
  always_comb begin
    allow_aw = aw_lock_q;
    allow_ar = ar_lock_q;
    allow_w  = 1'b0;
    case (state_q)
      ISO_RUN: begin
        allow_aw = aw_lock_q | ~wr_full;
        allow_ar = ar_lock_q | ~rd_full;
        allow_w  = 1'b1;
      end
      ISO_DRAIN: allow_w = ~wp_empty;
      default: ;
    endcase
  end

  assign mst_aw_valid_o = slv_aw_valid_i & allow_aw;
  assign slv_aw_ready_o = mst_aw_ready_i & allow_aw;
  assign mst_ar_valid_o = slv_ar_valid_i & allow_ar;
  assign slv_ar_ready_o = mst_ar_ready_i & allow_ar;
  assign mst_w_valid_o  = slv_w_valid_i & allow_w;
  assign slv_w_ready_o  = mst_w_ready_i & allow_w;

  assign slv_b_valid_o = mst_b_valid_i;
  assign mst_b_ready_o = slv_b_ready_i;
  assign slv_r_valid_o = mst_r_valid_i;
  assign mst_r_ready_o = slv_r_ready_i;

  assign aw_hs     = mst_aw_valid_o & mst_aw_ready_i;
  assign ar_hs     = mst_ar_valid_o & mst_ar_ready_i;
  assign w_last_hs = mst_w_valid_o & mst_w_ready_i & slv_w_last_i;
  assign b_hs      = mst_b_valid_i & slv_b_ready_i;
  assign r_last_hs = mst_r_valid_i & slv_r_ready_i & mst_r_last_i;

  axi_cdc_iso_cnt #(.Width(WrW)) i_wr_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (aw_hs),
    .dec_i   (b_hs),
    .max_i   (WrMax),
    .count_o (wr_outstanding_o),
    .full_o  (wr_full),
    .empty_o (wr_empty)
  );

  axi_cdc_iso_cnt #(.Width(RdW)) i_rd_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (ar_hs),
    .dec_i   (r_last_hs),
    .max_i   (RdMax),
    .count_o (rd_outstanding_o),
    .full_o  (rd_full),
    .empty_o (rd_empty)
  );

  // Write bursts whose address has gone downstream but whose last beat has not.
  axi_cdc_iso_cnt #(.Width(WrW)) i_wp_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (aw_hs),
    .dec_i   (w_last_hs),
    .max_i   (WrMax),
    .count_o (wp_count),
    .full_o  (wp_full),
    .empty_o (wp_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ISO_RUN;
      isolated_q <= 1'b0;
      aw_lock_q  <= 1'b0;
      ar_lock_q  <= 1'b0;
    end else begin
      aw_lock_q <= mst_aw_valid_o & ~mst_aw_ready_i;
      ar_lock_q <= mst_ar_valid_o & ~mst_ar_ready_i;
      case (state_q)
        ISO_RUN: begin
          if (isolate_req_i) state_q <= ISO_DRAIN;
        end
        ISO_DRAIN: begin
          if (!isolate_req_i) begin
            state_q <= ISO_RUN;
          end else if (wr_empty && rd_empty && wp_empty && !aw_lock_q && !ar_lock_q) begin
            state_q    <= ISO_ISOLATED;
            isolated_q <= 1'b1;
          end
        end
        ISO_ISOLATED: begin
          if (!isolate_req_i) begin
            state_q    <= ISO_RUN;
            isolated_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ISO_RUN;
          isolated_q <= 1'b0;
        end
      endcase
    end
  end

  assign isolated_o = isolated_q;

`ifdef AXI_CDC_ISO_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TimeoutCycles + 1);

  logic [ToW-1:0] drain_cycles_q;
  logic           timeout_q;

  // Flags a drain that is taking too long without forcing the state machine.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drain_cycles_q <= '0;
      timeout_q      <= 1'b0;
    end else begin
      if (state_q == ISO_DRAIN) begin
        if (drain_cycles_q != ToW'(TimeoutCycles)) drain_cycles_q <= drain_cycles_q + ToW'(1);
      end else begin
        drain_cycles_q <= '0;
      end
      if (!isolate_req_i) begin
        timeout_q <= 1'b0;
      end else if (state_q == ISO_DRAIN && drain_cycles_q == ToW'(TimeoutCycles - 1)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles == 0);
  assign timeout_o = 1'b0;
`endif

  assert property (@(posedge clk_i) disable iff (!rst_ni) !(b_hs && wr_empty));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(r_last_hs && rd_empty));

endmodule
